sdram_access_bridge: RTL and testbench

//  Sits between the KNN write/read sources (test-pattern writer, memory_control) and the SDRAM

---
 rtl/sdram_access_bridge_pkg.sv | 15 +
 rtl/sdram_access_bridge_sync_fifo.sv | 59 +++++
 rtl/sdram_access_bridge.sv | 174 +++++++++++++++++
 tb/tb_sdram_access_bridge.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_access_bridge_pkg.sv
// rtl/sdram_access_bridge_pkg.sv - shared widths and FSM encoding for the SDRAM access bridge
package sdram_access_bridge_pkg;

  localparam int DEF_W          = 16;
  localparam int DEF_ADDR_W     = 25;
  localparam int DEF_DEPTH_LOG2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_CMD  = 2'd2,
    ST_READ_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/sdram_access_bridge_sync_fifo.sv
// rtl/sdram_access_bridge_sync_fifo.sv - write-command FIFO with head and next-entry views
import sdram_access_bridge_pkg::*;

module sdram_access_bridge_sync_fifo #(
  parameter int WIDTH      = DEF_ADDR_W + DEF_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [WIDTH-1:0]      head_o,
  output logic [WIDTH-1:0]      next_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full_o  = count_q[DEPTH_LOG2];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PTR_ONE];

  // Full is judged on the registered count, so a same-cycle pop never rescues a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_access_bridge.sv
// rtl/sdram_access_bridge.sv - buffers write strobes and serialises reads onto an Avalon-MM master
module sdram_access_bridge
  import sdram_access_bridge_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] writeaddress_i,
  input  logic [W-1:0]      writedata_i,
  input  logic              read_i,
  input  logic [ADDR_W-1:0] readaddress_i,
  output logic [W-1:0]      readdata_o,
  output logic              readdata_valid_o,
  output logic              rd_busy_o,
  output logic              fifo_full_o,
  output logic              overflow_o,
  output logic              idle_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_write_o,
  output logic [W-1:0]      avm_writedata_o,
  output logic              avm_read_o,
  input  logic [W-1:0]      avm_readdata_i,
  input  logic              avm_readdatavalid_i,
  input  logic              avm_waitrequest_i
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;

  state_e                state_q, state_d;
  logic [ADDR_W+W-1:0]   fifo_head, fifo_next;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic                  rd_busy_q, rd_done;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic [ADDR_W-1:0]     avm_address_q, avm_address_d;
  logic [W-1:0]          avm_writedata_q, avm_writedata_d;
  logic                  avm_write_q, avm_write_d, avm_read_q, avm_read_d;
  logic [W-1:0]          readdata_q, readdata_d;
  logic                  readdata_valid_q, readdata_valid_d;
  logic                  overflow_q;

  sdram_access_bridge_sync_fifo #(
    .WIDTH      (ADDR_W + W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (write_i),
    .data_i  ({writeaddress_i, writedata_i}),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .next_o  (fifo_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)    state_d = ST_WRITE;
        else if (rd_busy_q) state_d = ST_READ_CMD;
      end
      ST_WRITE: begin
        if (!avm_waitrequest_i && !(fifo_count > CNT_ONE)) state_d = ST_IDLE;
      end
      ST_READ_CMD: begin
        if (!avm_waitrequest_i) state_d = avm_readdatavalid_i ? ST_IDLE : ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (avm_readdatavalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    avm_address_d    = avm_address_q;
    avm_writedata_d  = avm_writedata_q;
    avm_write_d      = avm_write_q;
    avm_read_d       = avm_read_q;
    readdata_d       = readdata_q;
    readdata_valid_d = 1'b0;
    fifo_pop         = 1'b0;
    rd_done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          {avm_address_d, avm_writedata_d} = fifo_head;
          avm_write_d = 1'b1;
        end else if (rd_busy_q) begin
          avm_address_d = rd_addr_q;
          avm_read_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        // Head stays in the FIFO until accepted; the next entry is preloaded for a gapless burst.
        if (!avm_waitrequest_i) begin
          fifo_pop = 1'b1;
          if (fifo_count > CNT_ONE) {avm_address_d, avm_writedata_d} = fifo_next;
          else                      avm_write_d = 1'b0;
        end
      end
      ST_READ_CMD: begin
        if (!avm_waitrequest_i) begin
          avm_read_d = 1'b0;
          if (avm_readdatavalid_i) begin
            readdata_d       = avm_readdata_i;
            readdata_valid_d = 1'b1;
            rd_done          = 1'b1;
          end
        end
      end
      ST_READ_WAIT: begin
        if (avm_readdatavalid_i) begin
          readdata_d       = avm_readdata_i;
          readdata_valid_d = 1'b1;
          rd_done          = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      avm_address_q    <= '0;
      avm_writedata_q  <= '0;
      avm_write_q      <= 1'b0;
      avm_read_q       <= 1'b0;
      readdata_q       <= '0;
      readdata_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
      rd_busy_q        <= 1'b0;
      rd_addr_q        <= '0;
    end else begin
      avm_address_q    <= avm_address_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_write_q      <= avm_write_d;
      avm_read_q       <= avm_read_d;
      readdata_q       <= readdata_d;
      readdata_valid_q <= readdata_valid_d;
      if (write_i && fifo_full) overflow_q <= 1'b1;
      if (rd_done) begin
        rd_busy_q <= 1'b0;
      end else if (read_i && !rd_busy_q) begin
        rd_busy_q <= 1'b1;
        rd_addr_q <= readaddress_i;
      end
    end
  end

  assign avm_address_o    = avm_address_q;
  assign avm_writedata_o  = avm_writedata_q;
  assign avm_write_o      = avm_write_q;
  assign avm_read_o       = avm_read_q;
  assign readdata_o       = readdata_q;
  assign readdata_valid_o = readdata_valid_q;
  assign rd_busy_o        = rd_busy_q;
  assign fifo_full_o      = fifo_full;
  assign overflow_o       = overflow_q;
  assign idle_o           = (state_q == ST_IDLE) && fifo_empty && !rd_busy_q;

endmodule

// File: tb/tb_sdram_access_bridge.sv
// tb/tb_sdram_access_bridge.sv - directed scoreboard bench for sdram_access_bridge
module tb_sdram_access_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        write, read;
  logic [24:0] writeaddress, readaddress;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        readdata_valid, rd_busy, fifo_full, overflow, idle;
  logic [24:0] avm_address;
  logic        avm_write, avm_read;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;

  int n_cmp = 0;
  int n_err = 0;
  int rd_acc = 0;
  int rd_base;

  logic [40:0] exp_wr[$];
  logic [24:0] exp_rd_addr[$];
  logic [15:0] exp_rd_data[$];

  always #5 clk = ~clk;

  sdram_access_bridge dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .write_i             (write),
    .writeaddress_i      (writeaddress),
    .writedata_i         (writedata),
    .read_i              (read),
    .readaddress_i       (readaddress),
    .readdata_o          (readdata),
    .readdata_valid_o    (readdata_valid),
    .rd_busy_o           (rd_busy),
    .fifo_full_o         (fifo_full),
    .overflow_o          (overflow),
    .idle_o              (idle),
    .avm_address_o       (avm_address),
    .avm_write_o         (avm_write),
    .avm_writedata_o     (avm_writedata),
    .avm_read_o          (avm_read),
    .avm_readdata_i      (avm_readdata),
    .avm_readdatavalid_i (avm_readdatavalid),
    .avm_waitrequest_i   (avm_waitrequest)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted Avalon commands and returned read data are popped in order.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", {23'd0, avm_address, avm_writedata}, 64'h0);
        else chk("wr_cmd", {23'd0, avm_address, avm_writedata}, {23'd0, exp_wr.pop_front()});
      end
      if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
        rd_acc++;
        if (exp_rd_addr.size() == 0) chk("rd_unexpected", {39'd0, avm_address}, 64'h0);
        else chk("rd_addr", {39'd0, avm_address}, {39'd0, exp_rd_addr.pop_front()});
      end
      if (readdata_valid === 1'b1) begin
        if (exp_rd_data.size() == 0) chk("rdata_unexpected", {48'd0, readdata}, 64'h0);
        else chk("rdata", {48'd0, readdata}, {48'd0, exp_rd_data.pop_front()});
      end
      if (avm_write === 1'b1) chk("wr_rd_exclusive", {63'd0, avm_read}, 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0;
    writeaddress = '0; writedata = '0; readaddress = '0;
    avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    repeat (3) step();
    chk("rst_avm_write", avm_write, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_avm_writedata", avm_writedata, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_rdv", readdata_valid, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;
    step();

    // 1: single write latency
    write = 1'b1; writeaddress = 25'h10; writedata = 16'h0005;
    exp_wr.push_back({25'h10, 16'h0005});
    step();
    write = 1'b0;
    chk("t1_not_yet", avm_write, 0);
    step();
    chk("t1_write", avm_write, 1);
    chk("t1_addr", avm_address, 25'h10);
    chk("t1_data", avm_writedata, 16'h0005);
    step();
    chk("t1_one_cycle", avm_write, 0);
    chk("t1_idle", idle, 1);

    // 2: fill, overflow, back-to-back drain
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; writeaddress = 25'h100 + 25'(i); writedata = 16'h00A0 + 16'(i);
      exp_wr.push_back({25'h100 + 25'(i), 16'h00A0 + 16'(i)});
      step();
    end
    chk("t2_full", fifo_full, 1);
    writeaddress = 25'h1FF; writedata = 16'hDEAD;
    step();
    write = 1'b0;
    chk("t2_overflow", overflow, 1);
    chk("t2_still_full", fifo_full, 1);
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_b2b", avm_write, 1);
      step();
    end
    chk("t2_done", avm_write, 0);
    chk("t2_not_full", fifo_full, 0);
    chk("t2_drained", exp_wr.size(), 0);

    // 3: read-after-write ordering
    avm_waitrequest = 1'b1;
    write = 1'b1; writeaddress = 25'h20; writedata = 16'h0003;
    exp_wr.push_back({25'h20, 16'h0003});
    step();
    write = 1'b0; read = 1'b1; readaddress = 25'h20;
    exp_rd_addr.push_back(25'h20); exp_rd_data.push_back(16'h0003);
    step();
    read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_rd_held", avm_read, 0);
      chk("t3_wr_held", avm_write, 1);
      step();
    end
    avm_waitrequest = 1'b0;
    for (int k = 0; k < 10 && avm_read !== 1'b1; k++) step();
    chk("t3_rd_issue", avm_read, 1);
    chk("t3_raw", exp_wr.size(), 0);
    step();
    chk("t3_rd_drop", avm_read, 0);
    chk("t3_busy", rd_busy, 1);
    avm_readdatavalid = 1'b1; avm_readdata = 16'h0003;
    step();
    avm_readdatavalid = 1'b0;
    chk("t3_rdv", readdata_valid, 1);
    chk("t3_rdata", readdata, 16'h0003);
    chk("t3_busy_clr", rd_busy, 0);
    step();
    chk("t3_rdv_pulse", readdata_valid, 0);
    chk("t3_idle", idle, 1);

    // 4: read while busy is ignored
    avm_waitrequest = 1'b1;
    read = 1'b1; readaddress = 25'h30;
    exp_rd_addr.push_back(25'h30); exp_rd_data.push_back(16'h1234);
    step();
    readaddress = 25'h40;
    step();
    read = 1'b0;
    chk("t4_rd", avm_read, 1);
    chk("t4_addr", avm_address, 25'h30);
    rd_base = rd_acc;
    avm_waitrequest = 1'b0;
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 16'h1234;
    step();
    avm_readdatavalid = 1'b0;
    chk("t4_rdv", readdata_valid, 1);
    repeat (4) step();
    chk("t4_one_txn", rd_acc, rd_base + 1);
    chk("t4_idle", idle, 1);

    // 6: readdatavalid together with waitrequest low in READ_CMD
    avm_waitrequest = 1'b1;
    read = 1'b1; readaddress = 25'h50;
    exp_rd_addr.push_back(25'h50); exp_rd_data.push_back(16'h00BE);
    step();
    read = 1'b0;
    step();
    chk("t6_rd", avm_read, 1);
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 16'h00BE;
    step();
    avm_readdatavalid = 1'b0;
    chk("t6_rdv", readdata_valid, 1);
    chk("t6_rdata", readdata, 16'h00BE);
    chk("t6_rd_low", avm_read, 0);
    chk("t6_busy_clr", rd_busy, 0);
    step();
    chk("t6_rdv_pulse", readdata_valid, 0);
    chk("t6_idle", idle, 1);

    // 5: reset abandons a stalled write
    chk("t5_sticky", overflow, 1);
    avm_waitrequest = 1'b1;
    write = 1'b1; writeaddress = 25'h300; writedata = 16'h0077;
    step();
    write = 1'b0;
    step();
    chk("t5_wr_held", avm_write, 1);
    rst = 1'b1;
    step();
    chk("t5_wr_abandon", avm_write, 0);
    chk("t5_overflow_clr", overflow, 0);
    chk("t5_full", fifo_full, 0);
    chk("t5_busy", rd_busy, 0);
    chk("t5_idle", idle, 1);
    rst = 1'b0; avm_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_fifo_empty", avm_write, 0);
    end
    chk("t5_idle_after", idle, 1);

    chk("end_wr_queue", exp_wr.size(), 0);
    chk("end_rd_queue", exp_rd_addr.size(), 0);
    chk("end_rdata_queue", exp_rd_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
